// File: rtl/data_memory_access_controller_pkg.sv
// Shared FSM encodings and defaults for the MEM-stage data memory access controller.
package data_memory_access_controller_pkg;

    localparam logic [1:0] DMAC_IDLE = 2'b00;
    localparam logic [1:0] DMAC_WAIT = 2'b01;
    localparam logic [1:0] DMAC_DONE = 2'b10;

    localparam int DMAC_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = DMAC_IDLE,
        ST_WAIT = DMAC_WAIT,
        ST_DONE = DMAC_DONE
    } dmac_state_t;

endpackage

// File: rtl/data_memory_access_controller_if.sv
// Pipeline-side and memory-side signals of the MEM-stage access controller.
// The slave modport is the controller's view; master is the surrounding pipeline/memory.
interface data_memory_access_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  MemtoRegM;
    logic                  MemWriteM;
    logic [ADDR_WIDTH-1:0] ALUOutM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic                  MemAck;
    logic [DATA_WIDTH-1:0] MemRData;
    logic                  ErrClr;
    logic                  MemReq;
    logic                  MemWe;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic                  StallM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic                  MemErr;

    modport master (
        output MemtoRegM, MemWriteM, ALUOutM, WriteDataM, MemAck, MemRData, ErrClr,
        input  MemReq, MemWe, MemAddr, MemWData, StallM, ReadDataM, MemErr
    );

    modport slave (
        input  MemtoRegM, MemWriteM, ALUOutM, WriteDataM, MemAck, MemRData, ErrClr,
        output MemReq, MemWe, MemAddr, MemWData, StallM, ReadDataM, MemErr
    );

endinterface

// File: rtl/data_memory_access_controller_access_timeout_counter.sv
// Counts WAIT cycles without an ack; tc flags the last permitted cycle. 1-cycle update.
// No backpressure: clr has priority over en, and the count saturates instead of wrapping.
module access_timeout_counter
    import data_memory_access_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMAC_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TIMEOUT_WIDTH-1:0] TC_VAL = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/data_memory_access_controller.sv
// Issues one registered req/ack memory access per MEM-stage load/store; stalls 2 cycles minimum,
// +1 per extra wait cycle, TIMEOUT_CYCLES+1 worst case, then releases for one DONE cycle.
module data_memory_access_controller
    import data_memory_access_controller_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DMAC_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 5
) (
    input  logic                          CLK,
    input  logic                          RST,
    data_memory_access_controller_if.slave bus
);

    dmac_state_t state, state_nxt;

    logic                  memop;
    logic                  start;
    logic                  done_ack;
    logic                  done_to;
    logic                  cnt_en;
    logic                  tc;
    logic                  stall;

    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign memop = bus.MemtoRegM | bus.MemWriteM;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memop) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                // Ack is checked first so a completion on the terminal cycle is not an error.
                if (bus.MemAck) begin
                    done_ack  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tc) begin
                    done_to   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    access_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .CLK (CLK),
        .RST (RST),
        .clr (start),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= bus.MemWriteM;
                addr_q  <= bus.ALUOutM;
                wdata_q <= bus.WriteDataM;
            end else if (done_ack || done_to) begin
                req_q <= 1'b0;
            end

            if (done_ack && !we_q) begin
                rdata_q <= bus.MemRData;
            end else if (done_to) begin
                rdata_q <= '0;
            end

            if (done_to) begin
                err_q <= 1'b1;
            end else if (bus.ErrClr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.MemReq    = req_q;
    assign bus.MemWe     = we_q;
    assign bus.MemAddr   = addr_q;
    assign bus.MemWData  = wdata_q;
    assign bus.ReadDataM = rdata_q;
    assign bus.MemErr    = err_q;
    // A held memop would otherwise re-assert the stall while reset is still low.
    assign bus.StallM    = stall & RST;

endmodule
